// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter and command sequencer for the single-port SPI RAM.
// Optional shadow address cache enabled by defining SPI_RAM_ADDR_CACHE_EN.
module spi_ram_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W+1:0] ram_din,
    output logic              ram_rx_valid,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_tx_valid
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RD_WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, id_q, last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                grant_vld, grant_id, hit;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [ADDR_W+1:0]   din_d;
    logic                rxv_d;

`ifdef SPI_RAM_ADDR_CACHE_EN
    logic [ADDR_W-1:0]   wa_shadow, ra_shadow;
    logic                wa_vld, ra_vld;
`endif

    always_comb begin
        grant_vld = req0 | req1;
        grant_id  = (req0 & req1) ? ~last_grant_q : req1;
        // Outputs are registered from the next state, so the command fields
        // come straight from the winning requester while still in IDLE.
        if (state_q == IDLE) begin
            sel_we    = grant_id ? we1    : we0;
            sel_addr  = grant_id ? addr1  : addr0;
            sel_wdata = grant_id ? wdata1 : wdata0;
        end else begin
            sel_we    = we_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
        end
`ifdef SPI_RAM_ADDR_CACHE_EN
        hit = sel_we ? (wa_vld && wa_shadow == sel_addr)
                     : (ra_vld && ra_shadow == sel_addr);
`else
        hit = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = hit ? DATA : ADDR;
            ADDR:    state_d = DATA;
            DATA:    state_d = we_q ? RESP : RD_WAIT;
            RD_WAIT: if (ram_tx_valid || cnt_q == CNT_MAX) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        din_d = '0;
        rxv_d = 1'b0;
        if (state_d == ADDR) begin
            rxv_d = 1'b1;
            din_d = {(sel_we ? 2'b00 : 2'b10), sel_addr};
        end else if (state_d == DATA) begin
            rxv_d = 1'b1;
            din_d = {(sel_we ? 2'b01 : 2'b11), (sel_we ? sel_wdata : {DATA_W{1'b0}})};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata        <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_vld) begin
                we_q         <= sel_we;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
            end
            cnt_q        <= (state_q == RD_WAIT) ? cnt_q + CNT_W'(1) : '0;
            ram_din      <= din_d;
            ram_rx_valid <= rxv_d;
            busy         <= (state_d != IDLE);
            done0        <= (state_d == RESP) && !id_q;
            done1        <= (state_d == RESP) && id_q;
            if (state_d == RESP && state_q == DATA) begin
                err <= 1'b0;
            end else if (state_d == RESP && state_q == RD_WAIT) begin
                rdata <= ram_tx_valid ? ram_dout : '0;
                err   <= !ram_tx_valid;
            end
        end
    end

`ifdef SPI_RAM_ADDR_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_shadow <= '0;
            ra_shadow <= '0;
            wa_vld    <= 1'b0;
            ra_vld    <= 1'b0;
        end else if (state_d == ADDR) begin
            if (sel_we) begin
                wa_shadow <= sel_addr;
                wa_vld    <= 1'b1;
            end else begin
                ra_shadow <= sel_addr;
                ra_vld    <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter with a behavioural SPI RAM model.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic       done0, done1, err, busy, ram_rx_valid;
    logic [7:0] rdata;
    logic [9:0] ram_din;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       ram_mute = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit         id;
        bit         rd;
        bit         err;
        logic [7:0] rdata;
    } resp_t;

    logic [9:0] cmd_q[$];
    resp_t      resp_q[$];

    always #5 clk = ~clk;

    spi_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err), .busy(busy),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    // RAM model: separate write/read address registers, registered read data
    logic [7:0] mem [256];
    logic [7:0] ram_wa = 0, ram_ra = 0;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        ram_tx_valid = 1'b0;
        ram_dout = 8'h00;
    end
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: ram_wa <= ram_din[7:0];
                2'b01: mem[ram_wa] <= ram_din[7:0];
                2'b10: ram_ra <= ram_din[7:0];
                2'b11: begin
                    ram_dout     <= mem[ram_ra];
                    ram_tx_valid <= !ram_mute;
                end
                default: ;
            endcase
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rx_valid) begin
                n_cmp++;
                if (cmd_q.size() == 0) begin
                    assert (ram_rx_valid === 1'b0) else begin
                        n_err++;
                        $error("FAIL cmd_unexpected got %h expected none", ram_din);
                    end
                end else begin
                    logic [9:0] e;
                    e = cmd_q.pop_front();
                    assert (ram_din === e) else begin
                        n_err++;
                        $error("FAIL cmd got %h expected %h", ram_din, e);
                    end
                end
            end
            if (done0 || done1) begin
                n_cmp++;
                assert ((done0 ^ done1) === 1'b1) else begin
                    n_err++;
                    $error("FAIL done_onehot got %b%b expected one-hot", done1, done0);
                end
                if (resp_q.size() == 0) begin
                    n_cmp++;
                    assert ((done0 | done1) === 1'b0) else begin
                        n_err++;
                        $error("FAIL done_unexpected got %b%b expected 00", done1, done0);
                    end
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    n_cmp++;
                    assert (done1 === r.id) else begin
                        n_err++;
                        $error("FAIL resp_id got %b expected %b", done1, r.id);
                    end
                    n_cmp++;
                    assert (err === r.err) else begin
                        n_err++;
                        $error("FAIL resp_err got %b expected %b", err, r.err);
                    end
                    if (r.rd) begin
                        n_cmp++;
                        assert (rdata === r.rdata) else begin
                            n_err++;
                            $error("FAIL resp_rdata got %h expected %h", rdata, r.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 0; req1 = 0; ram_mute = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic txn(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input bit exp_err, input int exp_lat,
                       input bit hit);
        resp_t r;
        int    lat;
        bit    got;
        if (!hit) cmd_q.push_back({(we ? 2'b00 : 2'b10), a});
        cmd_q.push_back({(we ? 2'b01 : 2'b11), (we ? d : 8'h00)});
        r.id = id; r.rd = !we; r.err = exp_err; r.rdata = exp_rd;
        resp_q.push_back(r);
        if (id) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1; end
        else    begin we0 = we; addr0 = a; wdata0 = d; req0 = 1; end
        lat = 0; got = 0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            if (id ? done1 : done0) got = 1;
        end
        if (id) req1 = 0; else req0 = 0;
        n_cmp++;
        assert (lat === exp_lat) else begin
            n_err++;
            $error("FAIL latency a=%h got %0d expected %0d", a, lat, exp_lat);
        end
        @(negedge clk);
    endtask

    initial begin
        resp_t r;
        int    n_done, cyc;
        bit    hit2;

        // Reset state
        #12;
        n_cmp++;
        assert ({done0, done1, rdata, err, busy, ram_din, ram_rx_valid} === 23'd0) else begin
            n_err++;
            $error("FAIL reset_outputs got %h expected 0",
                   {done0, done1, rdata, err, busy, ram_din, ram_rx_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back
        txn(0, 1, 8'h3C, 8'hA5, 8'h00, 0, 3, 0);
        txn(0, 0, 8'h3C, 8'h00, 8'hA5, 0, 4, 0);

        // Both requesters held: grants alternate starting with 0
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cmd_q.push_back(10'h201); cmd_q.push_back(10'h300);
            r.id = 0; r.rd = 1; r.err = 0; r.rdata = 8'h01 ^ 8'h5A; resp_q.push_back(r);
            cmd_q.push_back(10'h202); cmd_q.push_back(10'h300);
            r.id = 1; r.rd = 1; r.err = 0; r.rdata = 8'h02 ^ 8'h5A; resp_q.push_back(r);
        end
        we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
        req0 = 1; req1 = 1;
        n_done = 0; cyc = 0;
        while (n_done < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) n_done++;
        end
        req0 = 0; req1 = 0;
        n_cmp++;
        assert (n_done === 4) else begin
            n_err++;
            $error("FAIL rr_done_count got %0d expected 4", n_done);
        end
        @(negedge clk);

        // Read timeout: no tx_valid from the RAM
        ram_mute = 1;
        txn(1, 0, 8'h77, 8'h00, 8'h00, 1, 7, 0);
        ram_mute = 0;

        // Reset during the DATA cycle of a write
        cmd_q.push_back(10'h055);
        we0 = 1; addr0 = 8'h55; wdata0 = 8'h11; req0 = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        assert ({ram_rx_valid, done0, done1, busy} === 4'b0000) else begin
            n_err++;
            $error("FAIL reset_midop got %b expected 0000", {ram_rx_valid, done0, done1, busy});
        end
        req0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            assert (busy === 1'b0) else begin
                n_err++;
                $error("FAIL idle_after_reset got busy=%b expected 0", busy);
            end
        end
        txn(0, 1, 8'h55, 8'h11, 8'h00, 0, 3, 0);

        // Repeated read of one address; cache build skips ADDR on the second
`ifdef SPI_RAM_ADDR_CACHE_EN
        hit2 = 1;
`else
        hit2 = 0;
`endif
        txn(1, 0, 8'h10, 8'h00, 8'h10 ^ 8'h5A, 0, 4, 0);
        txn(1, 0, 8'h10, 8'h00, 8'h10 ^ 8'h5A, 0, hit2 ? 3 : 4, hit2);
        do_reset();
        txn(1, 0, 8'h10, 8'h00, 8'h10 ^ 8'h5A, 0, 4, 0);
        txn(0, 0, 8'h55, 8'h00, 8'h11, 0, 4, 0);

        repeat (3) @(negedge clk);
        n_cmp++;
        assert ((cmd_q.size() + resp_q.size()) === 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain got %0d pending expected 0", cmd_q.size() + resp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
